boa_csr_arbiter: RTL and testbench

BOA_CSR_ARBITER -- requirements
Module: boa_csr_arbiter

---
 rtl/boa_csr_arbiter_if.sv | 13 +
 rtl/boa_csr_arbiter.sv | 91 +++++++++
 tb/tb_boa_csr_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/boa_csr_arbiter_if.sv
// boa_csr_bus: zero-latency CSR access bus between an access master and the CSR file.
interface boa_csr_bus;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        exists;
    logic        rdonly;
    logic [1:0]  priv;
    logic [31:0] rdata;
    modport CPU    (output we, addr, wdata, input exists, rdonly, priv, rdata);
    modport master (output we, addr, wdata, input exists, rdonly, priv, rdata);
    modport slave  (input we, addr, wdata, output exists, rdonly, priv, rdata);
endinterface

// File: rtl/boa_csr_arbiter.sv
// boa_csr_arbiter: two-requester CSR arbiter sequencing read, optional read-modify-write, and ack.
// Define BOA_CSR_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module boa_csr_arbiter (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_i,
    input  logic [1:0][11:0] addr_i,
    input  logic [1:0][1:0]  wmode_i,
    input  logic [1:0][31:0] wmask_i,
    input  logic [1:0][1:0]  priv_i,
    output logic [1:0]       ack_o,
    output logic [31:0]      rdata_o,
    output logic             err_o,
    boa_csr_bus.CPU          csr
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
    state_e      state_q;
    logic        gnt_d, gnt_q, we_q, err_q, is_write, fault;
    logic [1:0]  wmode_q, priv_q, ack_q;
    logic [11:0] addr_q;
    logic [31:0] wmask_q, wdata_q, rdata_q, wdata_d;
`ifdef BOA_CSR_ARB_RR_EN
    logic        last_q;
    assign gnt_d = &req_i ? ~last_q : req_i[1];
`else
    assign gnt_d = ~req_i[0];
`endif
    // set/clear with an empty mask degrade to a plain read
    assign is_write = wmode_q == 2'b01 || (wmode_q[1] && |wmask_q);
    assign fault    = !csr.exists || priv_q < csr.priv || (is_write && csr.rdonly);
    assign wdata_d  = wmode_q == 2'b01 ? wmask_q : wmode_q[0] ? csr.rdata & ~wmask_q : csr.rdata | wmask_q;
    assign csr.we    = we_q;
    assign csr.addr  = addr_q;
    assign csr.wdata = wdata_q;
    assign ack_o     = ack_q;
    assign rdata_o   = rdata_q;
    assign err_o     = err_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            ack_q   <= 2'b00;
            wmode_q <= 2'b00;
            priv_q  <= 2'b00;
            addr_q  <= 12'h000;
            wmask_q <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
`ifdef BOA_CSR_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: if (|req_i) begin
                    gnt_q   <= gnt_d;
                    addr_q  <= addr_i[gnt_d];
                    wmode_q <= wmode_i[gnt_d];
                    wmask_q <= wmask_i[gnt_d];
                    priv_q  <= priv_i[gnt_d];
                    state_q <= READ;
`ifdef BOA_CSR_ARB_RR_EN
                    last_q  <= gnt_d;
`endif
                end
                READ: begin
                    rdata_q <= csr.rdata;
                    err_q   <= fault;
                    if (is_write && !fault) begin
                        we_q    <= 1'b1;
                        wdata_q <= wdata_d;
                        state_q <= WRITE;
                    end else begin
                        ack_q   <= {gnt_q, ~gnt_q};
                        state_q <= DONE;
                    end
                end
                WRITE: begin
                    we_q    <= 1'b0;
                    ack_q   <= {gnt_q, ~gnt_q};
                    state_q <= DONE;
                end
                DONE: begin
                    ack_q   <= 2'b00;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_boa_csr_arbiter.sv
// tb_boa_csr_arbiter: directed accesses against a transaction-level model of the CSR arbiter.
module tb_boa_csr_arbiter;
`ifdef BOA_CSR_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic             clk = 1'b0, rst_n = 1'b0, mon_en = 1'b0, last_gnt = 1'b1;
    logic [1:0]       req_i = '0;
    logic [1:0][11:0] addr_i = '0;
    logic [1:0][1:0]  wmode_i = '0, priv_i = '0;
    logic [1:0][31:0] wmask_i = '0;
    logic [1:0]       ack_o, exp_ack, ea, seen_ack;
    logic [31:0]      rdata_o, exp_wdata, exp_rdata, seen_wdata, seen_rdata;
    logic             err_o, exp_err, seen_err;
    logic [11:0]      exp_addr;
    logic [31:0]      csr_val [4096];
    logic             csr_ex [4096], csr_ro [4096];
    logic [1:0]       csr_pv [4096];
    int cyc = 0, checks = 0, errors = 0, start_cyc = 0, exp_ack_cyc = -1, exp_we_cyc = -1, seen_lat = -1, seen_we = 0;
    boa_csr_bus bus ();
    boa_csr_arbiter dut (.clk(clk), .rst_n(rst_n), .req_i(req_i), .addr_i(addr_i), .wmode_i(wmode_i),
        .wmask_i(wmask_i), .priv_i(priv_i), .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o), .csr(bus));
    assign bus.exists = csr_ex[bus.addr];
    assign bus.rdonly = csr_ro[bus.addr];
    assign bus.priv   = csr_pv[bus.addr];
    assign bus.rdata  = csr_val[bus.addr];
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", n, a, e, cyc);
        end
    endtask
    always @(negedge clk) if (mon_en) begin
        ea = (cyc == exp_ack_cyc) ? exp_ack : 2'b00;
        chk("ack", 32'(ack_o), 32'(ea));
        chk("we", 32'(bus.we), 32'(cyc == exp_we_cyc));
        if (cyc == exp_we_cyc) begin
            chk("wdata", bus.wdata, exp_wdata);
            chk("waddr", 32'(bus.addr), 32'(exp_addr));
        end
        if (ea != 2'b00) begin
            chk("rdata", rdata_o, exp_rdata);
            chk("err", 32'(err_o), 32'(exp_err));
        end
        if (bus.we) begin
            seen_we++;
            seen_wdata = bus.wdata;
        end
        if (ack_o != 2'b00) begin
            seen_ack   = ack_o;
            seen_lat   = cyc - start_cyc;
            seen_rdata = rdata_o;
            seen_err   = err_o;
        end
    end
    task automatic setreq(input int i, input logic [11:0] a, input logic [1:0] m, input logic [31:0] k, input logic [1:0] p);
        addr_i[i]  = a;
        wmode_i[i] = m;
        wmask_i[i] = k;
        priv_i[i]  = p;
    endtask
    // Called in an IDLE cycle with req_i already set; returns one cycle after the ack.
    task automatic serve(input logic [1:0] drop);
        int w, lat;
        logic wr, flt;
        logic [11:0] a;
        logic [1:0] md;
        logic [31:0] m, v, wd;
        w   = (req_i == 2'b11) ? (RR ? int'(!last_gnt) : 0) : int'(req_i[1]);
        a   = addr_i[w];
        md  = wmode_i[w];
        m   = wmask_i[w];
        v   = csr_val[a];
        wr  = md == 2'b01 || (md[1] && m != 0);
        flt = !csr_ex[a] || priv_i[w] < csr_pv[a] || (wr && csr_ro[a]);
        wd  = md == 2'b01 ? m : md == 2'b10 ? (v | m) : (v & ~m);
        lat = (wr && !flt) ? 3 : 2;
        start_cyc   = cyc;
        exp_ack_cyc = cyc + lat;
        exp_ack     = w == 1 ? 2'b10 : 2'b01;
        exp_we_cyc  = lat == 3 ? cyc + 2 : -1;
        exp_wdata   = wd;
        exp_addr    = a;
        exp_rdata   = v;
        exp_err     = flt;
        last_gnt    = w[0];
        seen_we = 0; seen_wdata = 0; seen_ack = 0; seen_lat = -1; seen_rdata = 0; seen_err = 0;
        @(posedge clk); #1;
        addr_i[w] = ~a; wmode_i[w] = ~md; wmask_i[w] = ~m;
        repeat (lat - 1) @(posedge clk);
        #1;
        addr_i[w] = a; wmode_i[w] = md; wmask_i[w] = m;
        if (lat == 3) csr_val[a] = wd;
        @(posedge clk); #1;
        req_i = req_i & ~drop;
    endtask
    task automatic res(input string n, input logic [1:0] a, input int lat, input logic e, input logic [31:0] rd, input int we, input logic [31:0] wd);
        chk({n, "_ack"}, 32'(seen_ack), 32'(a));
        chk({n, "_lat"}, 32'(seen_lat), 32'(lat));
        chk({n, "_err"}, 32'(seen_err), 32'(e));
        chk({n, "_rdata"}, seen_rdata, rd);
        chk({n, "_nwe"}, 32'(seen_we), 32'(we));
        if (we != 0) chk({n, "_wdata"}, seen_wdata, wd);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1);
    end
    initial begin
        for (int i = 0; i < 4096; i++) begin
            csr_val[i] = 32'h0; csr_ex[i] = 1'b0; csr_ro[i] = 1'b0; csr_pv[i] = 2'b00;
        end
        csr_ex[12'h340] = 1'b1;
        csr_ex[12'h300] = 1'b1; csr_val[12'h300] = 32'hF0;
        csr_ex[12'hF11] = 1'b1; csr_val[12'hF11] = 32'hF0; csr_ro[12'hF11] = 1'b1;
        csr_ex[12'h7B0] = 1'b1; csr_val[12'h7B0] = 32'h1234; csr_pv[12'h7B0] = 2'b11;
        csr_val[12'h123] = 32'hBAD00000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_we", 32'(bus.we), 32'h0);
        chk("rst_addr", 32'(bus.addr), 32'h0);
        chk("rst_wdata", bus.wdata, 32'h0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        setreq(0, 12'h340, 2'b01, 32'hDEADBEEF, 2'b11); req_i = 2'b01; serve(2'b01);
        res("write", 2'b01, 3, 1'b0, 32'h0, 1, 32'hDEADBEEF);
        setreq(0, 12'h300, 2'b10, 32'h0F, 2'b00); req_i = 2'b01; serve(2'b01);
        res("set", 2'b01, 3, 1'b0, 32'hF0, 1, 32'hFF);
        csr_val[12'h300] = 32'hF0;
        setreq(0, 12'h300, 2'b11, 32'h30, 2'b00); req_i = 2'b01; serve(2'b01);
        res("clear", 2'b01, 3, 1'b0, 32'hF0, 1, 32'hC0);
        setreq(0, 12'hF11, 2'b10, 32'h0, 2'b00); req_i = 2'b01; serve(2'b01);
        res("set0_ro", 2'b01, 2, 1'b0, 32'hF0, 0, 32'h0);
        setreq(0, 12'h123, 2'b00, 32'h0, 2'b11); req_i = 2'b01; serve(2'b01);
        res("f_noexist", 2'b01, 2, 1'b1, 32'hBAD00000, 0, 32'h0);
        setreq(0, 12'h7B0, 2'b00, 32'h0, 2'b00); req_i = 2'b01; serve(2'b01);
        res("f_priv", 2'b01, 2, 1'b1, 32'h1234, 0, 32'h0);
        setreq(0, 12'hF11, 2'b01, 32'h1, 2'b11); req_i = 2'b01; serve(2'b01);
        res("f_rdonly", 2'b01, 2, 1'b1, 32'hF0, 0, 32'h0);
        setreq(1, 12'h7B0, 2'b00, 32'h0, 2'b11); req_i = 2'b10; serve(2'b10);
        res("dbg_read", 2'b10, 2, 1'b0, 32'h1234, 0, 32'h0);
        setreq(0, 12'hF11, 2'b00, 32'h0, 2'b00); setreq(1, 12'h7B0, 2'b00, 32'h0, 2'b11);
        req_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            serve(i == 3 ? 2'b01 : 2'b00);
            chk("arb_seq", 32'(seen_ack), 32'(RR && i % 2 == 1 ? 2'b10 : 2'b01));
        end
        serve(2'b10);
        chk("arb_only1", 32'(seen_ack), 32'h2);
        setreq(0, 12'h123, 2'b00, 32'h0, 2'b11); req_i = 2'b01; serve(2'b01);
        res("pre_rst", 2'b01, 2, 1'b1, 32'hBAD00000, 0, 32'h0);
        setreq(1, 12'h340, 2'b01, 32'h55550000, 2'b11); req_i = 2'b10;
        start_cyc = cyc; exp_ack_cyc = -1; exp_we_cyc = cyc + 2;
        exp_wdata = 32'h55550000; exp_addr = 12'h340; seen_we = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_i = 2'b00;
        @(posedge clk); #1;
        chk("mid_rst_nwe", 32'(seen_we), 32'h1);
        chk("mid_rst_we", 32'(bus.we), 32'h0);
        chk("mid_rst_ack", 32'(ack_o), 32'h0);
        chk("mid_rst_err", 32'(err_o), 32'h0);
        chk("mid_rst_rdata", rdata_o, 32'h0);
        chk("mid_rst_addr", 32'(bus.addr), 32'h0);
        rst_n = 1'b1;
        last_gnt = 1'b1;
        exp_we_cyc = -1;
        setreq(0, 12'hF11, 2'b00, 32'h0, 2'b00); setreq(1, 12'h7B0, 2'b00, 32'h0, 2'b11);
        req_i = 2'b11; serve(2'b11);
        chk("post_rst_arb", 32'(seen_ack), 32'h1);
        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
